// File: rtl/mismatch_persist_monitor.sv
// Registered not-all-equal detector with persistence-filtered alarm
// and saturating mismatch-cycle counter for power telemetry.
module mismatch_persist_monitor #(
    parameter int WIDTH   = 3,
    parameter int PERSIST = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_cnt,
    output logic             mismatch,
    output logic             alarm,
    output logic [CNT_W-1:0] mis_cnt,
    output logic             cnt_sat
);

    localparam int RW = $clog2(PERSIST + 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(PERSIST);
    localparam logic [RW-1:0] RUN_LAST = RW'(PERSIST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ALARM
    } state_t;

    state_t           state, state_nxt;
    logic [RW-1:0]    run, run_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             s;

    assign s = en & ~((&din) | ~(|din));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            run      <= '0;
            mismatch <= 1'b0;
            mis_cnt  <= '0;
            cnt_sat  <= 1'b0;
        end else begin
            state    <= state_nxt;
            run      <= run_nxt;
            mismatch <= s;
            mis_cnt  <= cnt_nxt;
            cnt_sat  <= (cnt_nxt == CNT_MAX);
        end
    end

    always_comb begin
        run_nxt = '0;
        if (s) begin
            run_nxt = (run == RUN_MAX) ? run : run + RW'(1);
        end
    end

    always_comb begin
        cnt_nxt = mis_cnt;
        if (clr_cnt) begin
            cnt_nxt = '0;
        end else if (s && mis_cnt != CNT_MAX) begin
            cnt_nxt = mis_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = (PERSIST == 1) ? ALARM : PEND;
                end
            end
            PEND: begin
                if (!s) begin
                    state_nxt = IDLE;
                end else if (run == RUN_LAST) begin
                    state_nxt = ALARM;
                end
            end
            ALARM: begin
                if (!s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign alarm = (state == ALARM);

endmodule

// File: tb/tb_mismatch_persist_monitor.sv
// Directed bench for mismatch_persist_monitor: default-ish instance
// (WIDTH=3, PERSIST=4, CNT_W=4) plus a PERSIST=1, WIDTH=8 instance.
module tb_mismatch_persist_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] din;
    logic       clr_cnt;
    logic       mismatch;
    logic       alarm;
    logic [3:0] mis_cnt;
    logic       cnt_sat;

    logic       en2;
    logic [7:0] din2;
    logic       clr2;
    logic       mismatch2;
    logic       alarm2;
    logic [3:0] mis_cnt2;
    logic       cnt_sat2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mismatch_persist_monitor #(
        .WIDTH(3), .PERSIST(4), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
        .mismatch(mismatch), .alarm(alarm),
        .mis_cnt(mis_cnt), .cnt_sat(cnt_sat)
    );

    mismatch_persist_monitor #(
        .WIDTH(8), .PERSIST(1), .CNT_W(4)
    ) dut_p1 (
        .clk(clk), .rst(rst), .en(en2), .din(din2), .clr_cnt(clr2),
        .mismatch(mismatch2), .alarm(alarm2),
        .mis_cnt(mis_cnt2), .cnt_sat(cnt_sat2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; din = 3'b101; clr_cnt = 1'b0;
        step();
        step();
        n_tests++;
        if ({mismatch, alarm, mis_cnt, cnt_sat} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got m=%b a=%b c=%0d s=%b want all 0",
                     mismatch, alarm, mis_cnt, cnt_sat);
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (mismatch !== 1'b1 || mis_cnt !== 4'd1 || alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got m=%b c=%0d a=%b want m=1 c=1 a=0",
                     mismatch, mis_cnt, alarm);
        end
    endtask

    task automatic test_persist();
        apply_reset();
        en = 1'b1; din = 3'b101;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_tests++;
            if (mismatch !== 1'b1 || alarm !== (i == 4) || mis_cnt !== 4'(i)) begin
                n_fail++;
                $display("FAIL persist_edge%0d got m=%b a=%b c=%0d want m=1 a=%b c=%0d",
                         i, mismatch, alarm, mis_cnt, (i == 4), i);
            end
        end
        din = 3'b111;
        step();
        n_tests++;
        if (mismatch !== 1'b0 || alarm !== 1'b0 || mis_cnt !== 4'd4) begin
            n_fail++;
            $display("FAIL persist_fall got m=%b a=%b c=%0d want m=0 a=0 c=4",
                     mismatch, alarm, mis_cnt);
        end
    endtask

    task automatic test_en_break();
        logic seen_alarm;
        seen_alarm = 1'b0;
        apply_reset();
        en = 1'b1; din = 3'b011;
        for (int i = 0; i < 7; i++) begin
            en = (i != 3);
            step();
            if (alarm) seen_alarm = 1'b1;
            if (i == 3) begin
                n_tests++;
                if (mismatch !== 1'b0) begin
                    n_fail++;
                    $display("FAIL en_low_mismatch got %b want 0", mismatch);
                end
            end
        end
        n_tests++;
        if (seen_alarm !== 1'b0 || mis_cnt !== 4'd6) begin
            n_fail++;
            $display("FAIL en_break got alarm_seen=%b c=%0d want 0 c=6",
                     seen_alarm, mis_cnt);
        end
    endtask

    task automatic test_saturate_clear();
        int exp_c;
        apply_reset();
        en = 1'b1; din = 3'b110;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_c = (i > 15) ? 15 : i;
            n_tests++;
            if (mis_cnt !== 4'(exp_c) || cnt_sat !== (i >= 15) || alarm !== (i >= 4)) begin
                n_fail++;
                $display("FAIL sat_edge%0d got c=%0d s=%b a=%b want c=%0d s=%b a=%b",
                         i, mis_cnt, cnt_sat, alarm, exp_c, (i >= 15), (i >= 4));
            end
        end
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        n_tests++;
        if (mis_cnt !== 4'd0 || cnt_sat !== 1'b0 || alarm !== 1'b1 || mismatch !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_cnt got c=%0d s=%b a=%b m=%b want c=0 s=0 a=1 m=1",
                     mis_cnt, cnt_sat, alarm, mismatch);
        end
        step();
        n_tests++;
        if (mis_cnt !== 4'd1 || alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL after_clr got c=%0d a=%b want c=1 a=1", mis_cnt, alarm);
        end
    endtask

    task automatic test_reset_in_alarm();
        apply_reset();
        en = 1'b1; din = 3'b001;
        repeat (4) step();
        n_tests++;
        if (alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_alarm got %b want 1", alarm);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (alarm !== 1'b0 || mismatch !== 1'b0 || mis_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_in_alarm got a=%b m=%b c=%0d want 0 0 0",
                     alarm, mismatch, mis_cnt);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_tests++;
            if (alarm !== (i == 4)) begin
                n_fail++;
                $display("FAIL realarm_edge%0d got a=%b want %b", i, alarm, (i == 4));
            end
        end
    endtask

    task automatic test_persist_one();
        en2 = 1'b1; clr2 = 1'b0; din2 = 8'hFF;
        apply_reset();
        step();
        n_tests++;
        if (alarm2 !== 1'b0 || mismatch2 !== 1'b0) begin
            n_fail++;
            $display("FAIL p1_ff got a=%b m=%b want 0 0", alarm2, mismatch2);
        end
        din2 = 8'hFE;
        step();
        n_tests++;
        if (alarm2 !== 1'b1 || mismatch2 !== 1'b1 || mis_cnt2 !== 4'd1) begin
            n_fail++;
            $display("FAIL p1_fe got a=%b m=%b c=%0d want 1 1 1",
                     alarm2, mismatch2, mis_cnt2);
        end
        din2 = 8'h00;
        step();
        n_tests++;
        if (alarm2 !== 1'b0 || mismatch2 !== 1'b0) begin
            n_fail++;
            $display("FAIL p1_00 got a=%b m=%b want 0 0", alarm2, mismatch2);
        end
    endtask

    initial begin
        en2 = 1'b0; din2 = 8'h00; clr2 = 1'b0;
        test_reset();
        test_persist();
        test_en_break();
        test_saturate_clear();
        test_reset_in_alarm();
        test_persist_one();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
